// File: rtl/board_ram_ctrl.sv
// rtl/board_ram_ctrl.sv - board state RAM controller: clear sequencing, stone placement, colour counters
//
// Purpose: owns an external NxN cell-state RAM (sync write, comb read). Clears
// the board after reset or on request, validates and writes stone placements,
// keeps per-colour stone counts and shares the RAM read port with a display.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   clear_req                     one-cycle request to empty the board
//   place_valid/place_ready       placement handshake
//   place_x, place_y, place_color placement column, row and colour
//   resp_valid, resp_code         result pulse and held code (0 OK, 1 OCCUPIED, 2 BAD_COLOR)
//   board_ready, clear_done       board cleared flag and clear-finished pulse
//   black_count, white_count      stones on board per colour
//   disp_addr, disp_stall         display read address and stall flag
//   ram_*                         state RAM write port and read port
module board_ram_ctrl #(
  parameter int DATA_BITS      = 2,
  parameter int EDGE_ADDR_BITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_req,
  input  logic                        place_valid,
  output logic                        place_ready,
  input  logic [EDGE_ADDR_BITS-1:0]   place_x,
  input  logic [EDGE_ADDR_BITS-1:0]   place_y,
  input  logic [DATA_BITS-1:0]        place_color,
  output logic                        resp_valid,
  output logic [1:0]                  resp_code,
  output logic                        board_ready,
  output logic                        clear_done,
  output logic [2*EDGE_ADDR_BITS:0]   black_count,
  output logic [2*EDGE_ADDR_BITS:0]   white_count,
  input  logic [2*EDGE_ADDR_BITS-1:0] disp_addr,
  output logic                        disp_stall,
  output logic                        ram_wr_en,
  output logic [2*EDGE_ADDR_BITS-1:0] ram_wr_addr,
  output logic [DATA_BITS-1:0]        ram_wr_data,
  output logic [2*EDGE_ADDR_BITS-1:0] ram_rd_addr,
  input  logic [DATA_BITS-1:0]        ram_rd_data
);

  localparam int AW = 2 * EDGE_ADDR_BITS;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(1) << AW;

  localparam logic [1:0] RESP_OK        = 2'd0;
  localparam logic [1:0] RESP_OCCUPIED  = 2'd1;
  localparam logic [1:0] RESP_BAD_COLOR = 2'd2;

  localparam logic [DATA_BITS-1:0] COLOR_EMPTY   = DATA_BITS'(0);
  localparam logic [DATA_BITS-1:0] COLOR_BLACK   = DATA_BITS'(1);
  localparam logic [DATA_BITS-1:0] COLOR_WHITE   = DATA_BITS'(2);
  localparam logic [DATA_BITS-1:0] COLOR_INVALID = DATA_BITS'(3);

  typedef enum logic [2:0] {
    INIT_CLEAR,
    IDLE,
    CLEAR,
    CHECK,
    WRITE
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          clr_addr;
  logic                   clear_pending;
  logic [EDGE_ADDR_BITS-1:0] cap_x, cap_y;
  logic [DATA_BITS-1:0]   cap_color;

  logic clearing;
  logic bad_color;
  logic occupied;
  logic accept;

  assign clearing  = (state_q == INIT_CLEAR) || (state_q == CLEAR);
  assign bad_color = (cap_color == COLOR_EMPTY) || (cap_color == COLOR_INVALID);
  assign occupied  = (ram_rd_data != COLOR_EMPTY);
  assign accept    = place_valid && place_ready;

  always_comb begin
    state_d     = state_q;
    place_ready = 1'b0;
    disp_stall  = 1'b0;
    ram_rd_addr = disp_addr;
    ram_wr_en   = 1'b0;
    ram_wr_addr = {cap_y, cap_x};
    ram_wr_data = cap_color;
    case (state_q)
      INIT_CLEAR, CLEAR: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = clr_addr;
        ram_wr_data = COLOR_EMPTY;
        if (&clr_addr) state_d = IDLE;
      end
      IDLE: begin
        place_ready = !clear_req && !clear_pending;
        // Clear requests win over a simultaneous placement.
        if (clear_req || clear_pending) state_d = CLEAR;
        else if (place_valid)           state_d = CHECK;
      end
      CHECK: begin
        // The display loses the read port for this one cycle.
        disp_stall  = 1'b1;
        ram_rd_addr = {cap_y, cap_x};
        if (bad_color || occupied) state_d = IDLE;
        else                       state_d = WRITE;
      end
      WRITE: begin
        ram_wr_en = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = INIT_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INIT_CLEAR;
      clr_addr      <= '0;
      clear_pending <= 1'b0;
      board_ready   <= 1'b0;
      clear_done    <= 1'b0;
      black_count   <= '0;
      white_count   <= '0;
      resp_valid    <= 1'b0;
      resp_code     <= RESP_OK;
      cap_x         <= '0;
      cap_y         <= '0;
      cap_color     <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      clear_done <= 1'b0;

      if (clearing) begin
        clr_addr <= clr_addr + AW'(1);
        if (clr_addr == '0) begin
          black_count <= '0;
          white_count <= '0;
          board_ready <= 1'b0;
        end
        if (&clr_addr) begin
          clear_done  <= 1'b1;
          board_ready <= 1'b1;
        end
      end

      // In IDLE any request is consumed directly; elsewhere it is remembered,
      // and repeated requests collapse into the single pending flag.
      if (state_q == IDLE)  clear_pending <= 1'b0;
      else if (clear_req)   clear_pending <= 1'b1;

      if (accept) begin
        cap_x     <= place_x;
        cap_y     <= place_y;
        cap_color <= place_color;
      end

      if (state_q == CHECK) begin
        if (bad_color) begin
          resp_valid <= 1'b1;
          resp_code  <= RESP_BAD_COLOR;
        end else if (occupied) begin
          resp_valid <= 1'b1;
          resp_code  <= RESP_OCCUPIED;
        end
      end

      if (state_q == WRITE) begin
        resp_valid <= 1'b1;
        resp_code  <= RESP_OK;
        if (cap_color == COLOR_BLACK && black_count != CNT_MAX)
          black_count <= black_count + CW'(1);
        if (cap_color == COLOR_WHITE && white_count != CNT_MAX)
          white_count <= white_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_board_ram_ctrl.sv
// tb/tb_board_ram_ctrl.sv - self-checking bench for board_ram_ctrl
module tb_board_ram_ctrl;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic       place_valid;
  logic       place_ready;
  logic [2:0] place_x, place_y;
  logic [1:0] place_color;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic       board_ready;
  logic       clear_done;
  logic [6:0] black_count, white_count;
  logic [5:0] disp_addr;
  logic       disp_stall;
  logic       ram_wr_en;
  logic [5:0] ram_wr_addr;
  logic [1:0] ram_wr_data;
  logic [5:0] ram_rd_addr;
  logic [1:0] ram_rd_data;

  logic [1:0] mem [N];
  logic [1:0] model [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  board_ram_ctrl #(.DATA_BITS(2), .EDGE_ADDR_BITS(3)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .place_valid(place_valid), .place_ready(place_ready),
    .place_x(place_x), .place_y(place_y), .place_color(place_color),
    .resp_valid(resp_valid), .resp_code(resp_code),
    .board_ready(board_ready), .clear_done(clear_done),
    .black_count(black_count), .white_count(white_count),
    .disp_addr(disp_addr), .disp_stall(disp_stall),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_color(input logic [1:0] c);
    int n = 0;
    for (int i = 0; i < N; i++) if (model[i] == c) n++;
    return n;
  endfunction

  // Expects to be positioned in the first clear cycle (address 0).
  task automatic run_clear_checks(input string tag);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== 6'(i) || ram_wr_data !== 2'd0 || place_ready !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s clear cycle %0d: wr_en=%b addr=%0d data=%0d ready=%b resp_valid=%b, required 1/%0d/0/0/0",
                 tag, i, ram_wr_en, ram_wr_addr, ram_wr_data, place_ready, resp_valid, i);
      end
      step();
    end
    checks++;
    if (clear_done !== 1'b1 || board_ready !== 1'b1 || ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL %s clear end: clear_done=%b board_ready=%b wr_en=%b, required 1/1/0", tag, clear_done, board_ready, ram_wr_en);
    end
    checks++;
    if (black_count !== 7'd0 || white_count !== 7'd0) begin
      errors++;
      $display("FAIL %s counters after clear: black=%0d white=%0d, required 0/0", tag, black_count, white_count);
    end
    for (int i = 0; i < N; i++) model[i] = 2'd0;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (place_ready !== 1'b1 && w < 200) begin step(); w++; end
    checks++;
    if (place_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s place_ready timeout: got %b, required 1", tag, place_ready);
    end
  endtask

  // Full placement from handshake to response, checked against the board model.
  task automatic drive_place(input logic [2:0] x, input logic [2:0] y, input logic [1:0] c, input string tag);
    logic [5:0] a;
    logic [1:0] exp_code;
    bit         exp_ok;
    a = {y, x};
    wait_ready(tag);
    place_x = x; place_y = y; place_color = c; place_valid = 1'b1;
    disp_addr = 6'($urandom);
    step();
    place_valid = 1'b0;
    checks++;
    if (disp_stall !== 1'b1 || ram_rd_addr !== a) begin
      errors++;
      $display("FAIL %s check cycle: disp_stall=%b rd_addr=%0d, required 1/%0d", tag, disp_stall, ram_rd_addr, a);
    end
    exp_ok = 1'b0;
    if (c == 2'd0 || c == 2'd3) exp_code = 2'd2;
    else if (model[a] != 2'd0)  exp_code = 2'd1;
    else begin exp_code = 2'd0; exp_ok = 1'b1; end
    step();
    checks++;
    if (disp_stall !== 1'b0 || ram_rd_addr !== disp_addr) begin
      errors++;
      $display("FAIL %s stall release: disp_stall=%b rd_addr=%0d, required 0/%0d", tag, disp_stall, ram_rd_addr, disp_addr);
    end
    if (!exp_ok) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_code !== exp_code || ram_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL %s reject: resp_valid=%b code=%0d wr_en=%b, required 1/%0d/0", tag, resp_valid, resp_code, ram_wr_en, exp_code);
      end
    end else begin
      checks++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== a || ram_wr_data !== c || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s write: wr_en=%b addr=%0d data=%0d resp_valid=%b, required 1/%0d/%0d/0", tag, ram_wr_en, ram_wr_addr, ram_wr_data, resp_valid, a, c);
      end
      model[a] = c;
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_code !== 2'd0) begin
        errors++;
        $display("FAIL %s ok response: resp_valid=%b code=%0d, required 1/0", tag, resp_valid, resp_code);
      end
    end
    checks++;
    if (black_count !== 7'(count_color(2'd1)) || white_count !== 7'(count_color(2'd2))) begin
      errors++;
      $display("FAIL %s counters: black=%0d white=%0d, required %0d/%0d", tag, black_count, white_count, count_color(2'd1), count_color(2'd2));
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) mem[i] = 2'($urandom);
    rst = 1'b1;
    step();
    checks++;
    if (place_ready !== 1'b0 || resp_valid !== 1'b0 || resp_code !== 2'd0 || board_ready !== 1'b0 ||
        clear_done !== 1'b0 || disp_stall !== 1'b0 || black_count !== 7'd0 || white_count !== 7'd0) begin
      errors++;
      $display("FAIL reset values: ready=%b rv=%b code=%0d br=%b cd=%b stall=%b blk=%0d wht=%0d, required all 0",
               place_ready, resp_valid, resp_code, board_ready, clear_done, disp_stall, black_count, white_count);
    end
    rst = 1'b0;
    run_clear_checks("init");
    step();
    checks++;
    if (clear_done !== 1'b0 || board_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_done pulse width: clear_done=%b board_ready=%b, required 0/1", clear_done, board_ready);
    end
  endtask

  task automatic test_place_basic();
    drive_place(3'd3, 3'd2, 2'd1, "basic");
  endtask

  task automatic test_occupied();
    drive_place(3'd3, 3'd2, 2'd2, "occupied");
  endtask

  task automatic test_bad_color();
    drive_place(3'd5, 3'd6, 2'd3, "bad3");
    drive_place(3'd0, 3'd0, 2'd0, "bad0");
  endtask

  task automatic test_clear_during_check();
    logic [5:0] a;
    a = 6'($urandom);
    while (model[a] != 2'd0) a = a + 6'd1;
    wait_ready("clrchk");
    place_x = a[2:0]; place_y = a[5:3]; place_color = 2'd2; place_valid = 1'b1;
    step();
    place_valid = 1'b0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== a || place_ready !== 1'b0) begin
      errors++;
      $display("FAIL clrchk write: wr_en=%b addr=%0d ready=%b, required 1/%0d/0", ram_wr_en, ram_wr_addr, place_ready, a);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_code !== 2'd0 || place_ready !== 1'b0 || white_count !== 7'(count_color(2'd2) + 1)) begin
      errors++;
      $display("FAIL clrchk response: rv=%b code=%0d ready=%b white=%0d, required 1/0/0/%0d", resp_valid, resp_code, place_ready, white_count, count_color(2'd2) + 1);
    end
    step();
    run_clear_checks("clrchk");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      drive_place(3'($urandom), 3'($urandom), 2'($urandom), "random");
    for (int k = 0; k < 6; k++) begin
      logic [5:0] a;
      a = 6'($urandom);
      while (model[a] == 2'd0) a = a + 6'd1;
      drive_place(a[2:0], a[5:3], 2'($urandom_range(1, 2)), "rand_occ");
    end
    begin
      int bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== model[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL board contents: %0d cells differ, required 0", bad);
      end
    end
  endtask

  task automatic test_clear_and_place_same_cycle();
    wait_ready("same");
    clear_req = 1'b1; place_valid = 1'b1;
    place_x = 3'd1; place_y = 3'd1; place_color = 2'd1;
    #1;
    checks++;
    if (place_ready !== 1'b0) begin
      errors++;
      $display("FAIL same-cycle place_ready: got %b, required 0", place_ready);
    end
    step();
    clear_req = 1'b0;
    run_clear_checks("same");
    checks++;
    if (place_ready !== 1'b1) begin
      errors++;
      $display("FAIL same-cycle ready after clear: got %b, required 1", place_ready);
    end
    place_valid = 1'b0;
    drive_place(3'd1, 3'd1, 2'd1, "same_after");
  endtask

  task automatic test_reset_mid();
    wait_ready("rstmid");
    place_x = 3'd7; place_y = 3'd7; place_color = 2'd2; place_valid = 1'b1;
    step();
    place_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || place_ready !== 1'b0 || disp_stall !== 1'b0 || white_count !== 7'd0 || black_count !== 7'd0) begin
      errors++;
      $display("FAIL mid-op reset: rv=%b ready=%b stall=%b white=%0d black=%0d, required all 0", resp_valid, place_ready, disp_stall, white_count, black_count);
    end
    step();
    rst = 1'b0;
    run_clear_checks("rstmid");
    drive_place(3'd7, 3'd7, 2'd2, "rstmid_after");
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; place_valid = 1'b0;
    place_x = '0; place_y = '0; place_color = '0; disp_addr = '0;
    for (int i = 0; i < N; i++) model[i] = 2'd0;
    test_reset();
    test_place_basic();
    test_occupied();
    test_bad_color();
    test_clear_during_check();
    test_random();
    test_clear_and_place_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_ram_ctrl.md
BOARD_RAM_CTRL -- requirements
Module: board_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 2: cell state width; 0=empty, 1=black, 2=white, 3=invalid.
REQ-002 SHALL have parameter EDGE_ADDR_BITS, default 3: board edge is 2**EDGE_ADDR_BITS cells (8x8), N=2**(2*EDGE_ADDR_BITS) cells.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port clear_req, input, 1: one-cycle request to empty the board.
REQ-006 SHALL have port place_valid, input, 1: placement request valid.
REQ-007 SHALL have port place_ready, output, 1: placement request accepted when high with place_valid.
REQ-008 SHALL have ports place_x and place_y, input, EDGE_ADDR_BITS each: target column and row.
REQ-009 SHALL have port place_color, input, DATA_BITS: stone colour to place.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle result pulse.
REQ-011 SHALL have port resp_code, output, 2: 0=OK, 1=OCCUPIED, 2=BAD_COLOR; held until next resp_valid.
REQ-012 SHALL have port board_ready, output, 1: high once the board has been fully cleared.
REQ-013 SHALL have port clear_done, output, 1: one-cycle pulse when a clear finishes.
REQ-014 SHALL have ports black_count and white_count, output, 2*EDGE_ADDR_BITS+1 each: stones on board per colour.
REQ-015 SHALL have port disp_addr, input, 2*EDGE_ADDR_BITS, and port disp_stall, output, 1: display read request and stall flag.
REQ-016 SHALL have ports ram_wr_en (1), ram_wr_addr (2*EDGE_ADDR_BITS), ram_wr_data (DATA_BITS), ram_rd_addr (2*EDGE_ADDR_BITS), all outputs, and ram_rd_data (DATA_BITS), input: connection to the state RAM (synchronous write, combinational read).

Function
REQ-017 SHALL form cell address as {y, x}, row in the upper bits.
REQ-018 SHALL implement states INIT_CLEAR, IDLE, CLEAR, CHECK, WRITE.
REQ-019 SHALL, in INIT_CLEAR and CLEAR, write 0 to addresses 0..N-1 in ascending order, one per cycle (N cycles), then go to IDLE.
REQ-020 SHALL zero black_count and white_count on the first cycle of any clear and assert clear_done, plus set board_ready, in the cycle after the last clear write.
REQ-021 SHALL drive place_ready = (state==IDLE) && !clear_req && !clear_pending.
REQ-022 SHALL, in IDLE, give clear_req priority over place_valid.
REQ-023 SHALL latch clear_req arriving outside IDLE as clear_pending and start CLEAR from IDLE on the next cycle; repeated requests merge into one.
REQ-024 SHALL capture x, y and colour on acceptance at edge T, perform CHECK during cycle T+1, reading cell {y,x} via ram_rd_addr.
REQ-025 SHALL, in CHECK, reject with BAD_COLOR if colour is 0 or 3 (checked first), else reject with OCCUPIED if ram_rd_data != 0, else go to WRITE.
REQ-026 SHALL, in WRITE (cycle T+2), assert ram_wr_en for one cycle with the captured address and colour, and increment the matching counter.
REQ-027 SHALL pulse resp_valid at T+2 for rejects and at T+3 for OK; no RAM write occurs on reject.
REQ-028 SHALL drive ram_rd_addr = disp_addr except in CHECK, where disp_stall=1 and the controller address is used; disp_stall=0 otherwise.
REQ-029 SHALL keep ram_wr_en low in IDLE and CHECK; counters saturate at N.

Reset
REQ-030 SHALL on rst: state=INIT_CLEAR, clear address=0, clear_pending=0, board_ready=0, counters=0, resp_valid=0, resp_code=0, clear_done=0, disp_stall=0, place_ready=0.
REQ-031 SHALL, on rst asserted mid-operation, abandon the operation with no response and restart INIT_CLEAR after release.

Verification
REQ-032 Release rst -> ram_wr_en high N=64 consecutive cycles, addresses 0..63, data 0; clear_done one pulse; board_ready=1.
REQ-033 Place (x=3, y=2, colour=1) on empty board -> write at addr 19 data 1 at T+2, resp_valid at T+3 with code 0, black_count=1.
REQ-034 Repeat REQ-033 placement with colour 2 -> resp code 1 at T+2, no write, white_count=0.
REQ-035 Place colour 3 at an empty cell -> resp code 2 at T+2, no write; disp_stall high only during T+1.
REQ-036 clear_req during CHECK -> placement completes, then CLEAR runs 64 cycles; counters 0; place_ready low throughout.
REQ-037 clear_req and place_valid in the same IDLE cycle -> place_ready=0, CLEAR starts; placement accepted after clear_done.
